fp_cvt_sequencer: RTL and testbench
===================================

# fp_cvt_sequencer

Request-side sequencer and result stage for the floating-point convert unit. Buffers conversion requests in a small FIFO, drives the combinational convert datapath from registered state, and captures its result and exception flags into an output register with a valid/ready response. Resolves dynamic rounding mode, formats the 64-bit writeback value and maintains the sticky accrued-exception register.

## Interface
- `TAG_W`, 4: width of the request/response tag.
- `DEPTH`, 2: request FIFO entries; power of two, at least 2.

- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `flush` input 1: synchronous; empties FIFO and output register.
- `req_valid` input 1: request present.
- `req_ready` output 1: FIFO not full.
- `req_operand` input 64: source operand.
- `req_input_type` input 2: 00 FP32, 01 FP64, 10 INT32, 11 UINT32.
- `req_output_type` input 2: same encoding.
- `req_rm` input 3: rounding mode; 111 selects `frm`.
- `req_tag` input TAG_W: returned unchanged with the response.
- `frm` input 3: dynamic rounding mode, sampled at request acceptance.
- `cvt_operand` output 64, `cvt_input_type` output 2, `cvt_output_type` output 2, `cvt_rm` output 3: FIFO head fields, driven to the convert datapath.
- `cvt_result` input 64: convert datapath result.
- `cvt_flags` input 4: {invalid, overflow, underflow, inexact}.
- `rsp_valid` output 1, `rsp_ready` input 1: response handshake.
- `rsp_result` output 64: formatted result.
- `rsp_flags` output 4: per-operation flags, same bit order.
- `rsp_illegal` output 1: resolved rounding mode was illegal.
- `rsp_tag` output TAG_W: tag.
- `fflags` output 4: sticky accrued flags.
- `fflags_clr` input 1: clear sticky flags.

## Operation
- Acceptance: `req_valid && req_ready` at a rising edge writes one entry.
  - The entry holds operand, types, tag and the resolved rm: `frm` if `req_rm == 111`, else `req_rm`.
  - The rm is resolved at acceptance. A later change of `frm` does not affect entries already accepted.
- `req_ready` = FIFO not full. It is computed from occupancy only; a pop in the same cycle does not raise it.
- The FIFO head drives `cvt_*` directly from register outputs. Its values are don't-care when the FIFO is empty.
- Capture condition: FIFO non-empty and (output register empty, or `rsp_valid && rsp_ready`). On capture, the head is popped and the output register is loaded.
- Illegal rm: resolved rm of 101, 110 or 111 (a dynamic `frm` of 111 counts).
  - `rsp_illegal` = 1, `rsp_result` = 0, `rsp_flags` = 0.
  - `cvt_flags` are ignored.
- Result formatting:
  - FP64 output: `cvt_result` as is.
  - FP32 output: low 32 bits of `cvt_result`; upper half per Configuration.
  - INT32 and UINT32 outputs: `cvt_result[31:0]` sign-extended from bit 31 to 64 bits.
- Sticky flags:
  - Next value = (`fflags_clr` ? 0 : `fflags`) | (`rsp_valid && rsp_ready && !rsp_illegal` ? `rsp_flags` : 0).
  - A clear in the same cycle as a response handshake leaves exactly that response's flags.
- Flush:
  - FIFO occupancy and `rsp_valid` go to 0 at the next edge.
  - A request offered in the flush cycle is dropped; `req_ready` is treated as 0 that cycle.
  - `fflags` is unaffected. Flush has priority over capture and acceptance.
- Pointers wrap modulo DEPTH. A full/empty ambiguity is resolved with an extra pointer bit.

## Timing
- Reset: `req_ready` = 1; `rsp_valid`, `rsp_result`, `rsp_flags`, `rsp_illegal`, `rsp_tag`, `fflags` = 0; FIFO empty; `cvt_*` = 0.
- Reset mid-operation discards all queued and pending responses.
- Latency: a request accepted at edge k, into an empty block, is visible on `cvt_*` after k. It is captured at edge k+1, so `rsp_valid` is high from k+1.
- Throughput: one response per cycle while `rsp_ready` is held high.
- Response outputs are held stable while `rsp_valid && !rsp_ready`.
- Full stall: with `rsp_ready` low, DEPTH+1 requests are held (FIFO plus output register); then `req_ready` = 0.

## Configuration
- `FP_CVT_NANBOX_EN` defined: FP32 results have `rsp_result[63:32]` = 32'hFFFFFFFF (NaN-boxed).
- `FP_CVT_NANBOX_EN` undefined: FP32 results have `rsp_result[63:32]` = 0.
- The macro has no other effect.

## Test plan
- FP64→FP32, operand 0x3FF0000000000000, rm 000, `rsp_ready` = 1 -> `rsp_valid` one cycle after acceptance. `rsp_result` = 0xFFFFFFFF3F800000 with the macro, 0x000000003F800000 without. Flags 0.
- FP32→INT32 with `cvt_result` low word 0x80000000 -> `rsp_result` = 0xFFFFFFFF80000000. INT32 result 0x00000005 -> 0x0000000000000005.
- Three back-to-back requests with `rsp_ready` = 0 and DEPTH = 2 -> `req_ready` drops after the 3rd. After `rsp_ready` rises, tags return in order with one response per cycle.
- `req_rm` = 111 with `frm` = 010 -> `cvt_rm` = 010. Then `frm` = 101 -> `rsp_illegal` = 1, result 0, `fflags` unchanged.
- Response with `cvt_flags` = 1001 -> `fflags` = 1001. A following 0100 response -> 1101. `fflags_clr` on the same cycle as a 0001 response -> 0001.
- `flush` with two entries queued and `rsp_valid` high -> next cycle `rsp_valid` = 0, `req_ready` = 1, `fflags` retained. Async `rst_n` low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/fp_cvt_sequencer.sv
// Convert-unit sequencer: request FIFO -> convert datapath -> result register; FP32 NaN-boxing under FP_CVT_NANBOX_EN.
// Latency 1 cycle accept-to-response; req_ready = FIFO not full; response held while rsp_ready is low.
module fp_cvt_sequencer #(
  parameter int TAG_W = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_operand,
  input  logic [1:0]       req_input_type,
  input  logic [1:0]       req_output_type,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       frm,
  output logic [63:0]      cvt_operand,
  output logic [1:0]       cvt_input_type,
  output logic [1:0]       cvt_output_type,
  output logic [2:0]       cvt_rm,
  input  logic [63:0]      cvt_result,
  input  logic [3:0]       cvt_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [3:0]       fflags,
  input  logic             fflags_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;
`ifdef FP_CVT_NANBOX_EN
  localparam logic [31:0] FP32_UPPER = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] FP32_UPPER = 32'h0000_0000;
`endif

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [63:0]      op_q   [DEPTH];
  logic [1:0]       ityp_q [DEPTH];
  logic [1:0]       otyp_q [DEPTH];
  logic [2:0]       rm_q   [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_illegal_q, rsp_illegal_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [3:0]       fflags_q, fflags_d;

  logic             full, empty, push, pop, head_illegal;
  logic [2:0]       rm_res;
  logic [63:0]      fmt_result;
  logic [AW-1:0]    rd_idx;

  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign req_ready = !full;
  assign push   = req_valid && !full && !flush;
  assign pop    = !empty && (!rsp_valid_q || rsp_ready) && !flush;
  // Dynamic rm is frozen into the entry so later frm writes cannot affect it.
  assign rm_res = (req_rm == 3'b111) ? frm : req_rm;
  assign rd_idx = rd_ptr_q[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        ityp_q[i] <= '0;
        otyp_q[i] <= '0;
        rm_q[i]   <= '0;
        tag_q[i]  <= '0;
      end
    end else if (push) begin
      op_q[wr_ptr_q[AW-1:0]]   <= req_operand;
      ityp_q[wr_ptr_q[AW-1:0]] <= req_input_type;
      otyp_q[wr_ptr_q[AW-1:0]] <= req_output_type;
      rm_q[wr_ptr_q[AW-1:0]]   <= rm_res;
      tag_q[wr_ptr_q[AW-1:0]]  <= req_tag;
    end
  end

  assign cvt_operand     = op_q[rd_idx];
  assign cvt_input_type  = ityp_q[rd_idx];
  assign cvt_output_type = otyp_q[rd_idx];
  assign cvt_rm          = rm_q[rd_idx];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  assign head_illegal = (cvt_rm >= 3'b101);

  always_comb begin
    fmt_result = cvt_result;
    case (cvt_output_type)
      2'b00:   fmt_result = {FP32_UPPER, cvt_result[31:0]};
      2'b01:   fmt_result = cvt_result;
      default: fmt_result = {{32{cvt_result[31]}}, cvt_result[31:0]};
    endcase
  end

  always_comb begin
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_illegal_d = rsp_illegal_q;
    rsp_tag_d     = rsp_tag_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (pop) begin
      rsp_valid_d   = 1'b1;
      rsp_illegal_d = head_illegal;
      rsp_result_d  = head_illegal ? 64'd0 : fmt_result;
      rsp_flags_d   = head_illegal ? 4'd0 : cvt_flags;
      rsp_tag_d     = tag_q[rd_idx];
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // A clear coinciding with a handshake keeps only that response's flags.
  always_comb begin
    fflags_d = fflags_clr ? 4'd0 : fflags_q;
    if (rsp_valid_q && rsp_ready && !rsp_illegal_q) fflags_d = fflags_d | rsp_flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_illegal_q <= 1'b0;
      rsp_tag_q     <= '0;
      fflags_q      <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_illegal_q <= rsp_illegal_d;
      rsp_tag_q     <= rsp_tag_d;
      fflags_q      <= fflags_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_illegal = rsp_illegal_q;
  assign rsp_tag     = rsp_tag_q;
  assign fflags      = fflags_q;

endmodule

// File: tb/tb_fp_cvt_sequencer.sv
// Bench for fp_cvt_sequencer: directed cases plus random traffic against a queue-based reference model.
module tb_fp_cvt_sequencer;
  localparam int TAG_W = 4;
  localparam int DEPTH = 2;
`ifdef FP_CVT_NANBOX_EN
  localparam logic [31:0] NB = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] NB = 32'h0;
`endif

  logic clk = 0, rst_n = 0, flush = 0, req_valid = 0, rsp_ready = 0, fflags_clr = 0;
  logic [63:0] req_operand = 0;
  logic [1:0] req_input_type = 0, req_output_type = 0;
  logic [2:0] req_rm = 0, frm = 0;
  logic [TAG_W-1:0] req_tag = 0;
  logic req_ready, rsp_valid, rsp_illegal;
  logic [63:0] cvt_operand, cvt_result, rsp_result;
  logic [1:0] cvt_input_type, cvt_output_type;
  logic [2:0] cvt_rm;
  logic [3:0] cvt_flags, rsp_flags, fflags;
  logic [TAG_W-1:0] rsp_tag;

  fp_cvt_sequencer #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_operand(req_operand), .req_input_type(req_input_type), .req_output_type(req_output_type),
    .req_rm(req_rm), .req_tag(req_tag), .frm(frm), .cvt_operand(cvt_operand),
    .cvt_input_type(cvt_input_type), .cvt_output_type(cvt_output_type), .cvt_rm(cvt_rm),
    .cvt_result(cvt_result), .cvt_flags(cvt_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal), .rsp_tag(rsp_tag),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: swaps operand halves; flags come from operand bits 47:44.
  assign cvt_result = {cvt_operand[31:0], cvt_operand[63:32]};
  assign cvt_flags  = cvt_operand[47:44];

  typedef struct {
    logic [63:0]      res;
    logic [3:0]       flags;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  logic [3:0]  m_fflags = 0;
  logic        stall_prev = 0;
  logic [63:0] prev_result = 0;
  logic [TAG_W-1:0] prev_tag = 0;
  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [63:0] op, input logic [1:0] ot,
                                 input logic [2:0] rm, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic [63:0] dp;
    logic signed [31:0] lo;
    dp = {op[31:0], op[63:32]};
    lo = dp[31:0];
    e.tag = tag;
    e.ill = (rm == 3'd5) || (rm == 3'd6) || (rm == 3'd7);
    e.flags = e.ill ? 4'd0 : op[47:44];
    if (e.ill)           e.res = 64'd0;
    else if (ot == 2'b01) e.res = dp;
    else if (ot == 2'b00) e.res = {NB, dp[31:0]};
    else                  e.res = 64'(lo);
    return e;
  endfunction

  // Called at a negedge with this cycle's inputs already applied; advances one clock.
  task automatic tick();
    exp_t e;
    bit acc, hs;
    logic [2:0] rres;
    acc = req_valid && req_ready && !flush;
    hs  = rsp_valid && rsp_ready;
    check("req_ready", req_ready, q.size() < DEPTH + 1);
    check("fflags", fflags, m_fflags);
    if (stall_prev) begin
      check("hold_result", rsp_result, prev_result);
      check("hold_tag", rsp_tag, prev_tag);
    end
    if (fflags_clr) m_fflags = 0;
    if (hs) begin
      if (q.size() == 0) check("spurious_rsp", 1, 0);
      else begin
        e = q.pop_front();
        check("rsp_result", rsp_result, e.res);
        check("rsp_flags", rsp_flags, e.flags);
        check("rsp_illegal", rsp_illegal, e.ill);
        check("rsp_tag", rsp_tag, e.tag);
        if (!e.ill) m_fflags = m_fflags | e.flags;
      end
    end
    stall_prev  = rsp_valid && !rsp_ready && !flush;
    prev_result = rsp_result;
    prev_tag    = rsp_tag;
    if (flush) q.delete();
    else if (acc) begin
      rres = (req_rm == 3'b111) ? frm : req_rm;
      q.push_back(model(req_operand, req_output_type, rres, req_tag));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [63:0] op, input logic [1:0] ot, input logic [2:0] rm,
                      input logic [2:0] f, input logic [TAG_W-1:0] tag);
    req_operand = op; req_input_type = 2'b01; req_output_type = ot;
    req_rm = rm; frm = f; req_tag = tag; req_valid = 1;
    tick();
    req_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] snap;

  initial begin
    #23 rst_n = 1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_fflags", fflags, 0);
    check("rst_cvt_operand", cvt_operand, 0);
    check("rst_cvt_rm", cvt_rm, 0);

    // FP64 -> FP32 latency and formatting
    rsp_ready = 1;
    send(64'h3F80_0000_3FF0_0000, 2'b00, 3'b000, 3'b000, 4'h1);
    check("lat_cvt_operand", cvt_operand, 64'h3F80_0000_3FF0_0000);
    check("lat_vld_early", rsp_valid, 0);
    tick();
    check("lat_vld", rsp_valid, 1);
    check("fp32_result", rsp_result, {NB, 32'h3F80_0000});
    check("fp32_flags", rsp_flags, 0);
    tick();

    // INT32 sign extension
    send(64'h8000_0000_0000_0000, 2'b10, 3'b001, 3'b000, 4'h2);
    tick();
    check("int32_neg", rsp_result, 64'hFFFF_FFFF_8000_0000);
    tick();
    send(64'h0000_0005_0000_0000, 2'b10, 3'b001, 3'b000, 4'h3);
    tick();
    check("int32_pos", rsp_result, 64'h5);
    tick();

    // Dynamic rounding mode
    send(64'h1111_0000_2222_3333, 2'b01, 3'b111, 3'b010, 4'h4);
    check("dyn_rm", cvt_rm, 3'b010);
    idle(2);
    snap = m_fflags;
    send(64'h0000_F000_1234_5678, 2'b01, 3'b111, 3'b101, 4'h5);
    tick();
    check("ill_flag", rsp_illegal, 1);
    check("ill_result", rsp_result, 0);
    tick();
    check("ill_fflags", fflags, snap);

    // Sticky flags
    send(64'h0000_9000_0000_0000, 2'b01, 3'b000, 3'b000, 4'h6);
    idle(2);
    check("fflags_9", fflags, 4'b1001);
    send(64'h0000_4000_0000_0000, 2'b01, 3'b000, 3'b000, 4'h7);
    idle(2);
    check("fflags_d", fflags, 4'b1101);
    send(64'h0000_1000_0000_0000, 2'b01, 3'b000, 3'b000, 4'h8);
    tick();
    fflags_clr = 1;
    tick();
    fflags_clr = 0;
    check("fflags_clr_hs", fflags, 4'b0001);

    // Full stall then in-order drain
    rsp_ready = 0;
    send(64'h0000_0000_0000_0001, 2'b01, 3'b000, 3'b000, 4'h1);
    send(64'h0000_0000_0000_0002, 2'b01, 3'b000, 3'b000, 4'h2);
    send(64'h0000_0000_0000_0003, 2'b01, 3'b000, 3'b000, 4'h3);
    check("full_req_ready", req_ready, 0);
    rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      check("stream_vld", rsp_valid, 1);
      check("stream_tag", rsp_tag, i + 1);
      tick();
    end

    // Flush with queued entries and a request offered in the flush cycle
    rsp_ready = 0;
    send(64'h0000_2000_0000_0001, 2'b01, 3'b000, 3'b000, 4'h9);
    send(64'h0000_2000_0000_0002, 2'b01, 3'b000, 3'b000, 4'hA);
    send(64'h0000_2000_0000_0003, 2'b01, 3'b000, 3'b000, 4'hB);
    snap = m_fflags;
    flush = 1; req_valid = 1; req_tag = 4'hC;
    tick();
    flush = 0; req_valid = 0;
    check("flush_vld", rsp_valid, 0);
    check("flush_ready", req_ready, 1);
    check("flush_fflags", fflags, snap);
    rsp_ready = 1;
    idle(3);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      req_valid       = ($urandom_range(0, 3) != 0);
      req_operand     = {$urandom, $urandom};
      req_input_type  = 2'($urandom);
      req_output_type = 2'($urandom);
      req_rm          = ($urandom_range(0, 3) == 0) ? 3'b111 : 3'($urandom);
      frm             = 3'($urandom);
      req_tag         = TAG_W'($urandom);
      rsp_ready       = ($urandom_range(0, 2) != 0);
      flush           = ($urandom_range(0, 40) == 0);
      fflags_clr      = ($urandom_range(0, 20) == 0);
      tick();
    end
    req_valid = 0; flush = 0; fflags_clr = 0; rsp_ready = 1;
    idle(6);
    check("drain_empty", q.size(), 0);

    // Asynchronous reset mid-stream
    rsp_ready = 0;
    send(64'h0000_7000_0000_00AA, 2'b01, 3'b000, 3'b000, 4'h1);
    send(64'h0000_7000_0000_00BB, 2'b01, 3'b000, 3'b000, 4'h2);
    #2 rst_n = 0;
    #1;
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_rsp_result", rsp_result, 0);
    check("arst_fflags", fflags, 0);
    check("arst_cvt_operand", cvt_operand, 0);
    check("arst_req_ready", req_ready, 1);
    q.delete(); m_fflags = 0; stall_prev = 0;
    @(negedge clk);
    rst_n = 1;
    rsp_ready = 1;
    send(64'h0000_0000_1234_5678, 2'b01, 3'b000, 3'b000, 4'h5);
    idle(3);
    check("post_rst_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
